input_port_ctrl: RTL and testbench

- Per-input-port buffer and wormhole controller for the mesh router. It sits directly upstream of the route-compute stage (computeR-family).
- Buffers incoming flits and presents the header destination byte to route compute. Latches the returned one-hot output-port request, then holds the switch request while streaming the packet until its tail flit.
- One instance per router input (L, E, N, W, S).

---
 rtl/noc_pkg.sv | 51 +++++
 rtl/flit_fifo.sv | 59 +++++
 rtl/input_port_ctrl.sv | 113 +++++++++++
 tb/tb_input_port_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// noc_pkg: shared flit, port and state definitions for the mesh router. rev 1.0
// ============================================================================
package noc_pkg;

  localparam int FLIT_W    = 10;
  localparam int NUM_PORTS = 5;

  localparam logic [1:0] FLIT_HDR    = 2'b10;
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TAIL   = 2'b01;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam logic [2:0] PORT_L = 3'd1;
  localparam logic [2:0] PORT_E = 3'd2;
  localparam logic [2:0] PORT_N = 3'd3;
  localparam logic [2:0] PORT_W = 3'd4;
  localparam logic [2:0] PORT_S = 3'd5;

  localparam int OH_L = 0;
  localparam int OH_E = 1;
  localparam int OH_W = 2;
  localparam int OH_S = 3;
  localparam int OH_N = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ROUTE  = 3'd1,
    ST_REQ    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  // HDR and SINGLE share type bit 1; TAIL and SINGLE share type bit 0.
  function automatic logic is_head(input logic [1:0] t);
    return t[1];
  endfunction

  function automatic logic is_tail(input logic [1:0] t);
    return t[0];
  endfunction

  function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
    logic [NUM_PORTS-1:0] m1;
    m1 = v - NUM_PORTS'(1);
    return (v != '0) && ((v & m1) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/flit_fifo.sv
`default_nettype none
// ============================================================================
// flit_fifo: circular flit buffer with occupancy count, no pass-through. rev 1.0
// ============================================================================
module flit_fifo #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int FLIT_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_flit,
  input  logic              pop,
  output logic [FLIT_W-1:0] head,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_flit;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/input_port_ctrl.sv
`default_nettype none
// ============================================================================
// input_port_ctrl: input flit buffer plus route/request/wormhole FSM. rev 1.0
// ============================================================================
module input_port_ctrl #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int FLIT_W = noc_pkg::FLIT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [FLIT_W-1:0]             in_flit,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [7:0]                    route_dest,
  input  logic [noc_pkg::NUM_PORTS-1:0] route_onehot,
  output logic [noc_pkg::NUM_PORTS-1:0] req,
  input  logic                          grant,
  output logic [FLIT_W-1:0]             out_flit,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          err
);

  import noc_pkg::*;

  state_t            state;
  logic [FLIT_W-1:0] head;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;
  logic              pop;
  logic [1:0]        head_type;

  flit_fifo #(
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .FLIT_W (FLIT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_flit (in_flit),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign head_type  = head[FLIT_W-1 -: 2];
  assign in_ready   = !full;
  assign route_dest = head[7:0];
  assign out_flit   = head;
  assign out_valid  = (state == ST_ACTIVE) && grant && (count != '0);
  assign busy       = (state != ST_IDLE);

  // The header stays at the FIFO head through ROUTE/REQ and leaves as the first ACTIVE pop.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE:   pop = !empty && !is_head(head_type);
      ST_ACTIVE: pop = out_valid && out_ready;
      ST_DRAIN:  pop = !empty;
      default:   pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      req   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (is_head(head_type)) state <= ST_ROUTE;
            else                    err   <= 1'b1;
          end
        end
        ST_ROUTE: begin
          if (is_onehot(route_onehot)) begin
            req   <= route_onehot;
            state <= ST_REQ;
          end else begin
            err   <= 1'b1;
            state <= ST_DRAIN;
          end
        end
        ST_REQ: begin
          if (grant) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (pop && is_tail(head_type)) begin
            req   <= '0;
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (pop && is_tail(head_type)) state <= ST_IDLE;
        end
        default: begin
          req   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_port_ctrl.sv
`default_nettype none
// ============================================================================
// tb_input_port_ctrl: directed + random bench with a packet-level stream model. rev 1.0
// ============================================================================
module tb_input_port_ctrl;

  import noc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] in_flit;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] route_dest;
  logic [4:0] route_onehot;
  logic [4:0] req;
  logic       grant;
  logic [9:0] out_flit;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  // Route compute stand-in: y=F gives no route, y=E gives two routes, else 1 << (x mod 5).
  function automatic logic [4:0] route_fn(input logic [7:0] d);
    logic [4:0] r;
    if (d[7:4] == 4'hF)      r = 5'b00000;
    else if (d[7:4] == 4'hE) r = 5'b00011;
    else                     r = 5'b00001 << (d[3:0] % 4'd5);
    return r;
  endfunction

  assign route_onehot = route_fn(route_dest);

  input_port_ctrl #(.DEPTH(4), .PTR_W(2), .FLIT_W(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_flit      (in_flit),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .route_dest   (route_dest),
    .route_onehot (route_onehot),
    .req          (req),
    .grant        (grant),
    .out_flit     (out_flit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .err          (err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream model: classifies every accepted flit by packet framing.
  typedef struct packed { logic [9:0] f; logic [4:0] r; } exp_t;
  localparam int M_IDLE = 0, M_FWD = 1, M_DROP = 2;
  exp_t       exp_q[$];
  exp_t       mon_e;
  int         pst;
  logic [4:0] cur_r;
  logic       exp_err;
  int         exp_total;
  logic [9:0] tx_q[$];
  logic       acc_q;
  logic       rnd_mode;
  int         out_cnt;
  logic       req_seen, ov_seen;
  logic [9:0] last_out;
  logic [4:0] last_req;

  function automatic void flush_model();
    exp_q.delete();
    pst       = M_IDLE;
    cur_r     = '0;
    exp_err   = 1'b0;
    exp_total = 0;
    out_cnt   = 0;
    req_seen  = 1'b0;
    ov_seen   = 1'b0;
  endfunction

  function automatic void model_accept(input logic [9:0] f);
    logic [1:0] t;
    logic       ends;
    t    = f[9:8];
    ends = (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    case (pst)
      M_IDLE: begin
        if (t == FLIT_HDR || t == FLIT_SINGLE) begin
          cur_r = route_fn(f[7:0]);
          if ($countones(cur_r) == 1) begin
            exp_q.push_back('{f: f, r: cur_r});
            exp_total++;
            pst = ends ? M_IDLE : M_FWD;
          end else begin
            exp_err = 1'b1;
            pst = ends ? M_IDLE : M_DROP;
          end
        end else begin
          exp_err = 1'b1;
        end
      end
      M_FWD: begin
        exp_q.push_back('{f: f, r: cur_r});
        exp_total++;
        if (ends) pst = M_IDLE;
      end
      default: if (ends) pst = M_IDLE;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        acc_q = 1'b1;
        model_accept(in_flit);
      end
      if (out_valid) check("ov_without_grant", grant, 1);
      if (out_valid && out_ready) begin
        out_cnt++;
        last_out = out_flit;
        last_req = req;
        if (exp_q.size() == 0) begin
          check("out_extra", 0, 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_flit", out_flit, mon_e.f);
          check("out_req", req, mon_e.r);
        end
      end
      if (req != '0) req_seen = 1'b1;
      if (out_valid)  ov_seen  = 1'b1;
    end
  end

  // Input driver: presents the head of tx_q, gapped randomly in random mode.
  initial begin
    in_valid = 1'b0;
    in_flit  = '0;
    forever begin
      @(posedge clk); #1;
      if (acc_q && tx_q.size() > 0) void'(tx_q.pop_front());
      acc_q = 1'b0;
      if (tx_q.size() > 0 && (!rnd_mode || $urandom_range(3) != 0)) begin
        in_valid = 1'b1;
        in_flit  = tx_q[0];
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_mode) begin
        grant     = ($urandom_range(9) < 7);
        out_ready = ($urandom_range(9) < 7);
      end
    end
  end

  task automatic wait_quiet(input string tag);
    int q = 0;
    int n = 0;
    while (q < 8 && n < 5000) begin
      @(negedge clk); #1;
      n++;
      if (tx_q.size() == 0 && !in_valid && !busy) q++;
      else q = 0;
    end
    check({tag, "_quiet"}, (q >= 8), 1);
  endtask

  task automatic apply_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    tx_q.delete();
    acc_q = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [4:0] t1_req [7] = '{5'h00, 5'h00, 5'h02, 5'h02, 5'h02, 5'h02, 5'h00};
  logic       t1_ov  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [9:0] t1_of  [7] = '{10'h0, 10'h0, 10'h0, 10'h221, 10'h0AA, 10'h1BB, 10'h0};

  initial begin
    int n;
    logic [7:0] dest;
    rnd_mode  = 1'b0;
    grant     = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    acc_q     = 1'b0;
    flush_model();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_req", req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);

    // Basic packet with exact latency.
    grant = 1'b1; out_ready = 1'b1;
    tx_q.push_back(10'h221); tx_q.push_back(10'h0AA); tx_q.push_back(10'h1BB);
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("t1_req_c%0d", k), req, t1_req[k]);
      check($sformatf("t1_ov_c%0d", k), out_valid, t1_ov[k]);
      if (t1_ov[k]) check($sformatf("t1_flit_c%0d", k), out_flit, t1_of[k]);
    end
    wait_quiet("t1");
    check("t1_drained", exp_q.size(), 0);

    // Fill to DEPTH with the crossbar stalled, then one pop and a wrapped write.
    out_ready = 1'b0; out_cnt = 0;
    tx_q.push_back(10'h222); tx_q.push_back(10'h001); tx_q.push_back(10'h002);
    tx_q.push_back(10'h003); tx_q.push_back(10'h144);
    n = 0;
    while (in_ready && n < 50) begin @(negedge clk); n++; end
    check("t2_full", in_ready, 0);
    repeat (2) @(negedge clk);
    check("t2_held_full", in_ready, 0);
    check("t2_fifth_pending", tx_q.size(), 1);
    check("t2_active_ov", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("t2_space_after_pop", in_ready, 1);
    check("t2_next_head", out_flit, 10'h001);
    @(posedge clk);
    @(negedge clk);
    check("t2_refull", in_ready, 0);
    out_ready = 1'b1;
    wait_quiet("t2");
    check("t2_outs", out_cnt, 5);
    check("t2_drained", exp_q.size(), 0);

    // Grant gap mid-packet.
    out_cnt = 0;
    tx_q.push_back(10'h223);
    for (int i = 1; i <= 5; i++) tx_q.push_back(10'(i + 'h10));
    tx_q.push_back(10'h16F);
    n = 0;
    while (out_cnt < 2 && n < 100) begin @(negedge clk); #1; n++; end
    check("t3_started", (out_cnt >= 2), 1);
    @(posedge clk); #1 grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t3_gap_ov%0d", i), out_valid, 0);
      check($sformatf("t3_gap_req%0d", i), req, 5'b01000);
      @(posedge clk); #1;
    end
    grant = 1'b1;
    wait_quiet("t3");
    check("t3_outs", out_cnt, 7);
    check("t3_drained", exp_q.size(), 0);

    // Stray BODY in IDLE, then a SINGLE.
    out_cnt = 0;
    tx_q.push_back(10'h055); tx_q.push_back(10'h310);
    wait_quiet("t4");
    check("t4_err", err, 1);
    check("t4_outs", out_cnt, 1);
    check("t4_flit", last_out, 10'h310);
    check("t4_req", last_req, 5'b00001);

    // No route: drain whole packet.
    apply_reset();
    @(negedge clk);
    check("t5_err_cleared", err, 0);
    tx_q.push_back(10'h2F3); tx_q.push_back(10'h0CC); tx_q.push_back(10'h1DD);
    wait_quiet("t5");
    check("t5_err", err, 1);
    check("t5_outs", out_cnt, 0);
    check("t5_req_seen", req_seen, 0);
    check("t5_ov_seen", ov_seen, 0);
    tx_q.push_back(10'h311);
    wait_quiet("t5b");
    check("t5_after_outs", out_cnt, 1);
    check("t5_after_flit", last_out, 10'h311);

    // Asynchronous reset while ACTIVE with two flits queued.
    out_ready = 1'b0;
    tx_q.push_back(10'h224); tx_q.push_back(10'h031);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("t6_active", out_valid, 1);
    check("t6_req", req, 5'b10000);
    #2 rst_n = 1'b0;
    tx_q.delete(); acc_q = 1'b0; flush_model();
    #1;
    check("t6_rst_req", req, 0);
    check("t6_rst_ov", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_post_in_ready", in_ready, 1);
    check("t6_post_busy", busy, 0);
    check("t6_post_ov_seen", ov_seen, 0);

    // Random traffic against the stream model.
    rnd_mode = 1'b1;
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(9) == 0)
        tx_q.push_back({($urandom_range(1) ? FLIT_BODY : FLIT_TAIL), 8'($urandom)});
      dest = 8'($urandom);
      case ($urandom_range(9))
        0: dest[7:4] = 4'hF;
        1: dest[7:4] = 4'hE;
        default: if (dest[7:4] >= 4'hE) dest[7:4] = 4'h3;
      endcase
      if ($urandom_range(3) == 0) begin
        tx_q.push_back({FLIT_SINGLE, dest});
      end else begin
        tx_q.push_back({FLIT_HDR, dest});
        n = $urandom_range(3);
        for (int b = 0; b < n; b++) tx_q.push_back({FLIT_BODY, 8'($urandom)});
        tx_q.push_back({FLIT_TAIL, 8'($urandom)});
      end
    end
    wait_quiet("rnd");
    rnd_mode = 1'b0;
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_outs", out_cnt, exp_total);
    check("rnd_err", err, exp_err);
    check("rnd_req_idle", req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
